// File: rtl/password_checker_if.sv
// Entry-stage / door-actuator signal bundle for password_checker.
// Macro PW_CHANGE_EN adds the code-reprogramming handshake (set_pw / pw_changed).
`timescale 1ns/1ps
interface password_checker_if #(
  parameter int PW_WIDTH = 11
);
  logic                password_ready;
  logic [PW_WIDTH-1:0] entered_password;
  logic                door_unlock;
  logic                access_granted;
  logic                access_denied;
  logic                locked_out;
  logic                alarm;
  logic [3:0]          fail_count;
`ifdef PW_CHANGE_EN
  logic                set_pw;
  logic                pw_changed;

  modport master (
    output password_ready, entered_password, set_pw,
    input  door_unlock, access_granted, access_denied, locked_out, alarm,
           fail_count, pw_changed
  );

  modport slave (
    input  password_ready, entered_password, set_pw,
    output door_unlock, access_granted, access_denied, locked_out, alarm,
           fail_count, pw_changed
  );
`else
  modport master (
    output password_ready, entered_password,
    input  door_unlock, access_granted, access_denied, locked_out, alarm,
           fail_count
  );

  modport slave (
    input  password_ready, entered_password,
    output door_unlock, access_granted, access_denied, locked_out, alarm,
           fail_count
  );
`endif
endinterface

// File: rtl/password_checker.sv
// Password comparison, door-open window, failed-attempt count and timed alarm lockout.
// Macro PW_CHANGE_EN enables reprogramming the stored code while the door is open.
`timescale 1ns/1ps
module password_checker #(
  parameter int                  PW_WIDTH    = 11,
  parameter logic [PW_WIDTH-1:0] DEFAULT_PW  = 11'h234,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  OPEN_CYCLES = 500,
  parameter int                  LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  password_checker_if.slave bus
);

  localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]       FAIL_MAX  = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  function automatic logic codes_match(input logic [PW_WIDTH-1:0] a,
                                       input logic [PW_WIDTH-1:0] b);
    return (a == b);
  endfunction

  state_e              state_r, state_s;
  logic                ready_in_r, ready_q_r;
  logic [PW_WIDTH-1:0] pw_in_r;
  logic [PW_WIDTH-1:0] cap_pw_r, cap_pw_s;
  logic [TMR_W-1:0]    timer_r, timer_s;
  logic [3:0]          fail_r, fail_s;
  logic                door_r, door_s;
  logic                granted_r, granted_s;
  logic                denied_r, denied_s;
  logic                lock_r, lock_s;
  logic [PW_WIDTH-1:0] code_s;
  logic                new_entry_s;

`ifdef PW_CHANGE_EN
  logic                set_in_r;
  logic [PW_WIDTH-1:0] code_r, code_nxt_s;
  logic                changed_r, changed_s;

  assign code_s         = code_r;
  assign bus.pw_changed = changed_r;
`else
  assign code_s = DEFAULT_PW;
`endif

  // Inputs are registered once, so the edge detector works on the registered level.
  assign new_entry_s = ready_in_r & ~ready_q_r;

  // State, timer, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ready_in_r <= 1'b0;
      ready_q_r  <= 1'b0;
      pw_in_r    <= {PW_WIDTH{1'b0}};
      cap_pw_r   <= {PW_WIDTH{1'b0}};
      timer_r    <= TMR_ZERO;
      fail_r     <= 4'd0;
      door_r     <= 1'b0;
      granted_r  <= 1'b0;
      denied_r   <= 1'b0;
      lock_r     <= 1'b0;
`ifdef PW_CHANGE_EN
      set_in_r   <= 1'b0;
      code_r     <= DEFAULT_PW;
      changed_r  <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      ready_in_r <= bus.password_ready;
      ready_q_r  <= ready_in_r;
      pw_in_r    <= bus.entered_password;
      cap_pw_r   <= cap_pw_s;
      timer_r    <= timer_s;
      fail_r     <= fail_s;
      door_r     <= door_s;
      granted_r  <= granted_s;
      denied_r   <= denied_s;
      lock_r     <= lock_s;
`ifdef PW_CHANGE_EN
      set_in_r   <= bus.set_pw;
      code_r     <= code_nxt_s;
      changed_r  <= changed_s;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cap_pw_s  = cap_pw_r;
    timer_s   = timer_r;
    fail_s    = fail_r;
    door_s    = door_r;
    granted_s = 1'b0;
    denied_s  = 1'b0;
    lock_s    = lock_r;
`ifdef PW_CHANGE_EN
    code_nxt_s = code_r;
    changed_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (new_entry_s) begin
          cap_pw_s = pw_in_r;
          state_s  = ST_CHECK;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (codes_match(cap_pw_r, code_s)) begin
          granted_s = 1'b1;
          fail_s    = 4'd0;
          door_s    = 1'b1;
          timer_s   = OPEN_LOAD;
          state_s   = ST_OPEN;
        end else begin
          denied_s = 1'b1;
          fail_s   = fail_r + 4'd1;
          // fail_r is always below FAIL_MAX here, so the count cannot pass it
          if ((fail_r + 4'd1) == FAIL_MAX) begin
            lock_s  = 1'b1;
            timer_s = LOCK_LOAD;
            state_s = ST_LOCKOUT;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
`ifdef PW_CHANGE_EN
        if (new_entry_s && set_in_r) begin
          code_nxt_s = pw_in_r;
          changed_s  = 1'b1;
          timer_s    = OPEN_LOAD;
        end else if (timer_r == TMR_ZERO) begin
          door_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
`else
        if (timer_r == TMR_ZERO) begin
          door_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
`endif
      end
      ST_LOCKOUT: begin
        if (timer_r == TMR_ZERO) begin
          lock_s  = 1'b0;
          fail_s  = 4'd0;
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        door_s  = 1'b0;
        lock_s  = 1'b0;
      end
    endcase
  end

  assign bus.door_unlock    = door_r;
  assign bus.access_granted = granted_r;
  assign bus.access_denied  = denied_r;
  assign bus.locked_out     = lock_r;
  assign bus.alarm          = lock_r;
  assign bus.fail_count     = fail_r;

endmodule

// File: tb/tb_password_checker.sv
// Self-checking bench for password_checker: directed scenarios then randomized entries,
// each checked against a transaction-level model of the access rules.
`timescale 1ns/1ps
module tb_password_checker;

  localparam int          OPEN_C = 500;
  localparam int          LOCK_C = 1000;
  localparam int          MAXT   = 3;
  localparam logic [10:0] DEF_PW = 11'h234;

  logic clk;
  logic reset_n;

  password_checker_if #(.PW_WIDTH(11)) bus ();

  password_checker #(
    .PW_WIDTH   (11),
    .DEFAULT_PW (11'h234),
    .MAX_TRIES  (3),
    .OPEN_CYCLES(500),
    .LOCK_CYCLES(1000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_fail;
  logic [10:0] m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_door"},  bus.door_unlock,    1'b0);
    chk({tag, "_grant"}, bus.access_granted, 1'b0);
    chk({tag, "_deny"},  bus.access_denied,  1'b0);
    chk({tag, "_lock"},  bus.locked_out,     1'b0);
    chk({tag, "_alarm"}, bus.alarm,          1'b0);
    chk({tag, "_fail"},  bus.fail_count,     4'd0);
`ifdef PW_CHANGE_EN
    chk({tag, "_chg"},   bus.pw_changed,     1'b0);
`endif
  endtask

  task automatic reset_and_check();
    bus.password_ready = 1'b0;
`ifdef PW_CHANGE_EN
    bus.set_pw = 1'b0;
`endif
    reset_n = 1'b0;
    #1;
    outputs_zero("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    m_fail = 0;
    m_code = DEF_PW;
  endtask

  // One entry: raise ready with pw, check latency and outcome, then follow any window.
  task automatic do_entry(input logic [10:0] pw, input int hold, input int inj_at,
                          input logic [10:0] inj_pw, input int rst_at,
                          input int chg_at, input logic [10:0] chg_pw);
    bit exp_grant, exp_lock, alarm_bad, was_reset;
    int exp_fail, exp_len, cnt, pulses, chgs;
    exp_grant = (pw == m_code);
    if (exp_grant) begin
      exp_fail = 0;
      exp_lock = 1'b0;
      exp_len  = OPEN_C;
    end else begin
      exp_fail = m_fail + 1;
      exp_lock = (exp_fail == MAXT);
      exp_len  = exp_lock ? LOCK_C : 0;
    end
    bus.password_ready   = 1'b1;
    bus.entered_password = pw;
    tick();
    tick();
    chk("early_grant", bus.access_granted, 1'b0);
    chk("early_deny",  bus.access_denied,  1'b0);
    tick();
    chk("grant",  bus.access_granted, exp_grant);
    chk("deny",   bus.access_denied,  !exp_grant);
    chk("fail",   bus.fail_count,     exp_fail);
    chk("door",   bus.door_unlock,    exp_grant);
    chk("locked", bus.locked_out,     exp_lock);
    chk("alarm",  bus.alarm,          exp_lock);
    m_fail = exp_lock ? 0 : exp_fail;
    if (exp_len == 0) begin
      bus.password_ready = 1'b0;
      tick();
      chk("deny_pulse_end", bus.access_denied, 1'b0);
      chk("deny_no_door",   bus.door_unlock,   1'b0);
      return;
    end
    cnt = 0; pulses = 0; chgs = 0; alarm_bad = 1'b0; was_reset = 1'b0;
    while (((exp_grant && bus.door_unlock === 1'b1) ||
            (!exp_grant && bus.locked_out === 1'b1)) && cnt < 3000) begin
      if (cnt == hold) bus.password_ready = 1'b0;
      if (cnt == inj_at) begin
        bus.password_ready   = 1'b1;
        bus.entered_password = inj_pw;
      end
      if (cnt == inj_at + 3) bus.password_ready = 1'b0;
      if (cnt > 0 && (bus.access_granted !== 1'b0 || bus.access_denied !== 1'b0)) pulses++;
      if (bus.alarm !== bus.locked_out) alarm_bad = 1'b1;
`ifdef PW_CHANGE_EN
      if (bus.pw_changed === 1'b1) chgs++;
      if (cnt == chg_at) begin
        bus.password_ready   = 1'b1;
        bus.entered_password = chg_pw;
        bus.set_pw           = 1'b1;
      end
      if (cnt == chg_at + 3) begin
        bus.password_ready = 1'b0;
        bus.set_pw         = 1'b0;
      end
`endif
      if (cnt == rst_at) begin
        reset_and_check();
        was_reset = 1'b1;
        break;
      end
      cnt++;
      tick();
    end
    bus.password_ready = 1'b0;
    if (!was_reset) begin
`ifdef PW_CHANGE_EN
      if (chg_at >= 0) begin
        chk("chg_window_len", cnt, exp_len + chg_at + 2);
        chk("chg_pulses", chgs, 1);
        m_code = chg_pw;
      end else begin
        chk("window_len", cnt, exp_len);
      end
`else
      chk("window_len", cnt, exp_len);
`endif
      chk("window_pulses", pulses, 0);
      chk("window_alarm_tracks", alarm_bad, 1'b0);
      chk("after_door",  bus.door_unlock, 1'b0);
      chk("after_lock",  bus.locked_out,  1'b0);
      chk("after_alarm", bus.alarm,       1'b0);
      chk("after_fail",  bus.fail_count,  m_fail);
    end
  endtask

  initial begin
    logic [10:0] rpw;
    reset_n              = 1'b0;
    bus.password_ready   = 1'b0;
    bus.entered_password = 11'h000;
`ifdef PW_CHANGE_EN
    bus.set_pw           = 1'b0;
`endif
    m_fail = 0;
    m_code = DEF_PW;
    #2;
    outputs_zero("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    outputs_zero("idle");

    // Correct code opens the door for the full window.
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
    // Mismatch then match clears the count.
    do_entry(11'h111, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
    // Three misses lock out; the correct code during lockout is dropped.
    do_entry(11'h000, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h000, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h000, 1, 200, 11'h234, -1, -1, 11'h000);
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
    // Level held for 20 cycles is one entry; a new edge after the window is another.
    do_entry(11'h234, 20, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h234, 1, 50, 11'h234, -1, -1, 11'h000);
    // Reset in the middle of the door window and of a lockout.
    do_entry(11'h234, 1, -1, 11'h000, 100, -1, 11'h000);
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h7ff, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h001, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h235, 1, -1, 11'h000, 300, -1, 11'h000);
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
`ifdef PW_CHANGE_EN
    // Reprogram the code while open; the old code then fails and the new one works.
    do_entry(11'h234, 1, -1, 11'h000, -1, 50, 11'h155);
    do_entry(11'h234, 1, -1, 11'h000, -1, -1, 11'h000);
    do_entry(11'h155, 1, -1, 11'h000, -1, -1, 11'h000);
`endif

    for (int i = 0; i < 20; i++) begin
      rpw = ($urandom_range(0, 3) == 0) ? m_code : 11'($urandom);
      do_entry(rpw, $urandom_range(0, 10), $urandom_range(15, 400), 11'($urandom),
               -1, -1, 11'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
